apuf_eval_ctrl: RTL

Evaluation controller at the far end of the arbiter-PUF delay chain. It drives the per-stage challenge bits into the switch-element chain and fires the launch edge into both chain inputs. It then samples the arbiter output after each race and repeats the race N_EVAL times. The majority-voted response bit, with a ones count and a stability flag, is returned over a valid/ready handshake to the host-side controller.

---
 rtl/apuf_eval_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/apuf_eval_ctrl.sv
// Arbiter-PUF evaluation controller: applies a challenge, fires N_EVAL launch
// races, majority-votes the synchronized arbiter samples and hands back the result.
module apuf_eval_ctrl #(
  parameter int N_STAGES = 64,
  parameter int N_EVAL   = 15,
  parameter int SETTLE   = 4,
  parameter int RACE     = 4,
  parameter int CNT_W    = $clog2(N_EVAL + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                chal_valid,
  output logic                chal_ready,
  input  logic [N_STAGES-1:0] chal,
  output logic [N_STAGES-1:0] chain_c,
  output logic                launch,
  input  logic                arb_q,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp,
  output logic [CNT_W-1:0]    resp_ones,
  output logic                resp_stable
);

  localparam int TMAX  = (SETTLE > RACE) ? SETTLE : RACE;
  localparam int TMR_W = $clog2(TMAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] RACE_LAST   = TMR_W'(RACE - 1);
  localparam logic [CNT_W-1:0] EVAL_N      = CNT_W'(N_EVAL);
  localparam logic [CNT_W-1:0] EVAL_HALF   = CNT_W'(N_EVAL / 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_LAUNCH = 3'd2,
    S_RELAX  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_r;
  logic [TMR_W-1:0] tmr_r;
  logic [CNT_W-1:0] ones_r;
  logic [CNT_W-1:0] eval_r;
  logic             sync1_r;
  logic             arb_s;

  assign chal_ready = (state_r == S_IDLE);

  // Two-flop synchronizer: the only consumer of the asynchronous arbiter output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      arb_s   <= 1'b0;
    end else begin
      sync1_r <= arb_q;
      arb_s   <= sync1_r;
    end
  end

  // Sequencer: settle, launch/relax races, vote, and response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      tmr_r       <= '0;
      ones_r      <= '0;
      eval_r      <= '0;
      chain_c     <= '0;
      launch      <= 1'b0;
      resp_valid  <= 1'b0;
      resp        <= 1'b0;
      resp_ones   <= '0;
      resp_stable <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (chal_valid) begin
            chain_c <= chal;
            ones_r  <= '0;
            eval_r  <= '0;
            tmr_r   <= '0;
            state_r <= S_SETTLE;
          end else begin
            tmr_r <= '0;
          end
        end
        S_SETTLE: begin
          if (tmr_r == SETTLE_LAST) begin
            tmr_r   <= '0;
            launch  <= 1'b1;
            state_r <= S_LAUNCH;
          end else begin
            tmr_r <= tmr_r + TMR_W'(1);
          end
        end
        S_LAUNCH: begin
          // Sample on the last high edge so the arbiter gets RACE-2 cycles before the synchronizer.
          if (tmr_r == RACE_LAST) begin
            tmr_r   <= '0;
            launch  <= 1'b0;
            ones_r  <= ones_r + CNT_W'(arb_s);
            eval_r  <= eval_r + CNT_W'(1);
            state_r <= S_RELAX;
          end else begin
            tmr_r <= tmr_r + TMR_W'(1);
          end
        end
        S_RELAX: begin
          if (tmr_r == RACE_LAST) begin
            tmr_r <= '0;
            if (eval_r < EVAL_N) begin
              launch  <= 1'b1;
              state_r <= S_LAUNCH;
            end else begin
              resp_valid  <= 1'b1;
              resp        <= (ones_r > EVAL_HALF);
              resp_ones   <= ones_r;
              resp_stable <= (ones_r == '0) || (ones_r == EVAL_N);
              state_r     <= S_DONE;
            end
          end else begin
            tmr_r <= tmr_r + TMR_W'(1);
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_r    <= S_IDLE;
          end else begin
            resp_valid <= 1'b1;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          launch     <= 1'b0;
          resp_valid <= 1'b0;
          tmr_r      <= '0;
        end
      endcase
    end
  end

endmodule
